// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - vending controller state encoding and coin values
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_PREPARE = 3'd2,
      ST_READY   = 3'd3,
      ST_CHANGE  = 3'd4,
      ST_REFUND  = 3'd5
   } state_t;

   localparam int C20  = 20;
   localparam int C50  = 50;
   localparam int C100 = 100;

endpackage

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - idle-collect timeout counter
module vend_timer #(
   parameter int TIMEOUT_CYC = 4_000_000
) (
   input  logic clk4m,
   input  logic rst_n,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

   logic [W-1:0] cnt;

   // expired marks the last idle cycle, so the owner leaves on the edge closing it
   assign expired = enable && (cnt == LAST);

   always_ff @(posedge clk4m or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - coin-operated vending controller with change and refund
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int N_PROD      = 4,
   parameter int PRICE       = 60,
   parameter int MAX_CREDIT  = 300,
   parameter int CREDIT_W    = 9,
   parameter int TIMEOUT_CYC = 4_000_000
) (
   input  logic                clk4m,
   input  logic                rst_n,
   input  logic                cent20,
   input  logic                cent50,
   input  logic                euro01,
   input  logic [N_PROD-1:0]   sel,
   input  logic                stop_buy,
   input  logic                prod_ready,
   input  logic                cup_out,
   output logic [N_PROD-1:0]   prepare,
   output logic                green,
   output logic                lock_slit,
   output logic                return_cash,
   output logic [CREDIT_W-1:0] change_cents,
   output logic                reject_coin,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic [N_PROD-1:0]   prod_q, prod_d;
   logic                reject_q, reject_d;

   logic [CREDIT_W:0]   coin_val, coin_sum;
   logic                coin_any, coin_ok, accept, sel_valid;
   logic                tmr_restart, tmr_enable, tmr_expired;

   vend_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk4m   (clk4m),
      .rst_n   (rst_n),
      .restart (tmr_restart),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk4m or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         credit_q <= '0;
         change_q <= '0;
         prod_q   <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         change_q <= change_d;
         prod_q   <= prod_d;
         reject_q <= reject_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      change_d     = change_q;
      prod_d       = prod_q;
      prepare      = '0;
      green        = 1'b0;
      lock_slit    = 1'b0;
      return_cash  = 1'b0;
      change_cents = '0;
      busy         = (state_q != ST_IDLE);
      credit       = credit_q;
      reject_coin  = reject_q;

      coin_val = '0;
      if (cent20) coin_val = coin_val + (CREDIT_W+1)'(C20);
      if (cent50) coin_val = coin_val + (CREDIT_W+1)'(C50);
      if (euro01) coin_val = coin_val + (CREDIT_W+1)'(C100);
      coin_sum = {1'b0, credit_q} + coin_val;
      coin_any = cent20 | cent50 | euro01;

      // a whole cycle's coins are taken or refused together
      coin_ok  = ((state_q == ST_IDLE && !cup_out) || state_q == ST_COLLECT)
                 && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
      accept   = coin_any && coin_ok;
      reject_d = coin_any && !coin_ok;

      sel_valid   = (state_q == ST_COLLECT) && (|sel) && (credit_q >= CREDIT_W'(PRICE));
      tmr_enable  = (state_q == ST_COLLECT);
      tmr_restart = accept || (state_q != ST_COLLECT);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               credit_d = coin_sum[CREDIT_W-1:0];
               state_d  = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (accept) credit_d = coin_sum[CREDIT_W-1:0];
            if (stop_buy) begin
               state_d = ST_REFUND;
            end else if (sel_valid) begin
               // a coin landing with the selection goes into the change
               change_d = credit_d - CREDIT_W'(PRICE);
               credit_d = '0;
               prod_d   = sel & (~sel + N_PROD'(1));
               state_d  = ST_PREPARE;
            end else if (tmr_expired && !accept) begin
               state_d = ST_REFUND;
            end
         end
         ST_PREPARE: begin
            prepare   = prod_q;
            lock_slit = 1'b1;
            if (prod_ready) state_d = ST_READY;
         end
         ST_READY: begin
            green     = 1'b1;
            lock_slit = 1'b1;
            if (cup_out) state_d = (change_q != '0) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            return_cash  = 1'b1;
            change_cents = change_q;
            lock_slit    = 1'b1;
            change_d     = '0;
            state_d      = ST_IDLE;
         end
         ST_REFUND: begin
            return_cash  = 1'b1;
            change_cents = credit_q;
            lock_slit    = 1'b1;
            credit_d     = '0;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            credit_d = '0;
            change_d = '0;
            prod_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - self-checking bench for vend_ctrl with a transaction-level model
module tb_vend_ctrl;

   logic       clk4m = 1'b0;
   logic       rst_n;
   logic       cent20, cent50, euro01;
   logic [3:0] sel;
   logic       stop_buy, prod_ready, cup_out;
   logic [3:0] prepare;
   logic       green, lock_slit, return_cash, reject_coin, busy;
   logic [8:0] change_cents, credit;

   int n_tests = 0;
   int n_fail  = 0;

   vend_ctrl #(.TIMEOUT_CYC(10)) dut (
      .clk4m        (clk4m),
      .rst_n        (rst_n),
      .cent20       (cent20),
      .cent50       (cent50),
      .euro01       (euro01),
      .sel          (sel),
      .stop_buy     (stop_buy),
      .prod_ready   (prod_ready),
      .cup_out      (cup_out),
      .prepare      (prepare),
      .green        (green),
      .lock_slit    (lock_slit),
      .return_cash  (return_cash),
      .change_cents (change_cents),
      .reject_coin  (reject_coin),
      .credit       (credit),
      .busy         (busy)
   );

   always #5 clk4m = ~clk4m;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk4m);
      #1;
   endtask

   task automatic coin(input logic c20, input logic c50, input logic c100);
      cent20 = c20; cent50 = c50; euro01 = c100;
      tick();
      cent20 = 0; cent50 = 0; euro01 = 0;
   endtask

   task automatic pulse_sel(input logic [3:0] s);
      sel = s; tick(); sel = '0;
   endtask

   task automatic pulse_ready;
      prod_ready = 1; tick(); prod_ready = 0;
   endtask

   task automatic pulse_cup;
      cup_out = 1; tick(); cup_out = 0;
   endtask

   task automatic do_reset;
      rst_n = 0; #3;
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset;
      rst_n = 0; #3;
      n_tests++;
      if ({prepare, green, lock_slit, return_cash, change_cents, reject_coin, credit, busy} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got prepare=%b green=%b credit=%0d busy=%b want all 0", prepare, green, credit, busy);
      end
      tick(); rst_n = 1; tick();
   endtask

   task automatic test_exact_price;
      coin(1, 0, 0); coin(1, 0, 0); coin(1, 0, 0);
      n_tests++; if (credit !== 9'd60) begin n_fail++; $display("FAIL exact_credit: got %0d want 60", credit); end
      pulse_sel(4'b0001);
      n_tests++; if (prepare !== 4'b0001 || lock_slit !== 1'b1) begin n_fail++; $display("FAIL exact_prepare: got %b lock=%b want 0001 1", prepare, lock_slit); end
      pulse_ready();
      n_tests++; if (green !== 1'b1) begin n_fail++; $display("FAIL exact_green: got %b want 1", green); end
      pulse_cup();
      n_tests++; if (busy !== 1'b0 || return_cash !== 1'b0) begin n_fail++; $display("FAIL exact_idle: busy=%b return_cash=%b want 0 0", busy, return_cash); end
   endtask

   task automatic test_change;
      coin(0, 0, 1);
      pulse_sel(4'b0100);
      n_tests++; if (prepare !== 4'b0100) begin n_fail++; $display("FAIL change_prepare: got %b want 0100", prepare); end
      pulse_ready(); pulse_cup();
      n_tests++; if (return_cash !== 1'b1 || change_cents !== 9'd40) begin n_fail++; $display("FAIL change_pulse: rc=%b cents=%0d want 1 40", return_cash, change_cents); end
      tick();
      n_tests++; if (return_cash !== 1'b0 || change_cents !== 9'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL change_done: rc=%b cents=%0d busy=%b want 0 0 0", return_cash, change_cents, busy); end
   endtask

   task automatic test_simultaneous;
      coin(0, 1, 1);
      n_tests++; if (credit !== 9'd150) begin n_fail++; $display("FAIL simul_credit: got %0d want 150", credit); end
      pulse_sel(4'b1010);
      n_tests++; if (prepare !== 4'b0010) begin n_fail++; $display("FAIL simul_prepare: got %b want 0010", prepare); end
      pulse_ready(); pulse_cup();
      n_tests++; if (return_cash !== 1'b1 || change_cents !== 9'd90) begin n_fail++; $display("FAIL simul_change: rc=%b cents=%0d want 1 90", return_cash, change_cents); end
      tick();
   endtask

   task automatic test_refund;
      coin(0, 1, 0);
      stop_buy = 1; cent20 = 1; sel = 4'b0001;
      tick();
      stop_buy = 0; cent20 = 0; sel = '0;
      n_tests++; if (return_cash !== 1'b1 || change_cents !== 9'd70 || prepare !== 4'b0000) begin n_fail++; $display("FAIL refund_pulse: rc=%b cents=%0d prepare=%b want 1 70 0000", return_cash, change_cents, prepare); end
      tick();
      n_tests++; if (busy !== 1'b0 || credit !== 9'd0 || return_cash !== 1'b0) begin n_fail++; $display("FAIL refund_idle: busy=%b credit=%0d rc=%b want 0 0 0", busy, credit, return_cash); end
   endtask

   task automatic test_timeout;
      logic early;
      early = 1'b0;
      coin(1, 0, 0);
      for (int i = 0; i < 9; i++) begin
         tick();
         if (return_cash !== 1'b0 || busy !== 1'b1) early = 1'b1;
      end
      n_tests++; if (early) begin n_fail++; $display("FAIL timeout_early: refund before 10 idle cycles (got early=1 want 0)"); end
      tick();
      n_tests++; if (return_cash !== 1'b1 || change_cents !== 9'd20) begin n_fail++; $display("FAIL timeout_refund: rc=%b cents=%0d want 1 20", return_cash, change_cents); end
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_reject;
      coin(0, 1, 0); coin(1, 0, 0);
      pulse_sel(4'b1000);
      coin(1, 0, 0);
      n_tests++; if (reject_coin !== 1'b1 || credit !== 9'd0) begin n_fail++; $display("FAIL reject_prepare: rej=%b credit=%0d want 1 0", reject_coin, credit); end
      tick();
      n_tests++; if (reject_coin !== 1'b0) begin n_fail++; $display("FAIL reject_pulse_len: rej=%b want 0", reject_coin); end
      pulse_ready();
      n_tests++; if (green !== 1'b1) begin n_fail++; $display("FAIL reject_ready: green=%b want 1", green); end
      #2; rst_n = 0; #1;
      n_tests++;
      if ({prepare, green, lock_slit, return_cash, change_cents, reject_coin, credit, busy} !== '0) begin
         n_fail++; $display("FAIL reset_in_ready: green=%b lock=%b busy=%b want all 0", green, lock_slit, busy);
      end
      tick(); rst_n = 1; tick();
      coin(0, 0, 1); coin(0, 0, 1); coin(0, 0, 1);
      n_tests++; if (credit !== 9'd300 || reject_coin !== 1'b0) begin n_fail++; $display("FAIL ceiling_fill: credit=%0d rej=%b want 300 0", credit, reject_coin); end
      coin(0, 0, 1);
      n_tests++; if (reject_coin !== 1'b1 || credit !== 9'd300) begin n_fail++; $display("FAIL ceiling_reject: rej=%b credit=%0d want 1 300", reject_coin, credit); end
      stop_buy = 1; tick(); stop_buy = 0;
      n_tests++; if (change_cents !== 9'd300) begin n_fail++; $display("FAIL ceiling_refund: cents=%0d want 300", change_cents); end
      tick();
      cup_out = 1; coin(1, 0, 0); cup_out = 0;
      n_tests++; if (reject_coin !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cup_reject: rej=%b busy=%b want 1 0", reject_coin, busy); end
      tick();
   endtask

   task automatic test_random(input int n_txn);
      int         m_credit, val, ncoins, chg;
      logic [2:0] bits;
      logic [3:0] s, exp_oh;
      logic       exp_rej;
      for (int t = 0; t < n_txn; t++) begin
         m_credit = 0;
         ncoins = $urandom_range(1, 4);
         for (int c = 0; c < ncoins; c++) begin
            bits = 3'($urandom_range(1, 7));
            val  = (bits[0] ? 20 : 0) + (bits[1] ? 50 : 0) + (bits[2] ? 100 : 0);
            exp_rej = (m_credit + val > 300);
            if (!exp_rej) m_credit += val;
            coin(bits[0], bits[1], bits[2]);
            n_tests++; if (reject_coin !== exp_rej || int'(credit) !== m_credit) begin n_fail++; $display("FAIL rand_coin: rej=%b credit=%0d want %b %0d", reject_coin, credit, exp_rej, m_credit); end
         end
         s = 4'($urandom_range(1, 15));
         if (m_credit >= 60 && $urandom_range(0, 2) != 0) begin
            exp_oh = '0;
            for (int i = 3; i >= 0; i--) if (s[i]) exp_oh = 4'(1 << i);
            chg = m_credit - 60;
            pulse_sel(s);
            n_tests++; if (prepare !== exp_oh || credit !== 9'd0) begin n_fail++; $display("FAIL rand_prepare: prepare=%b credit=%0d want %b 0", prepare, credit, exp_oh); end
            repeat ($urandom_range(0, 3)) tick();
            pulse_ready();
            n_tests++; if (green !== 1'b1) begin n_fail++; $display("FAIL rand_green: green=%b want 1", green); end
            pulse_cup();
            if (chg > 0) begin
               n_tests++; if (return_cash !== 1'b1 || int'(change_cents) !== chg) begin n_fail++; $display("FAIL rand_change: rc=%b cents=%0d want 1 %0d", return_cash, change_cents, chg); end
               tick();
            end
            n_tests++; if (busy !== 1'b0 || return_cash !== 1'b0) begin n_fail++; $display("FAIL rand_buy_idle: busy=%b rc=%b want 0 0", busy, return_cash); end
         end else begin
            if (m_credit < 60) begin
               pulse_sel(s);
               n_tests++; if (prepare !== 4'b0000 || busy !== 1'b1 || int'(credit) !== m_credit) begin n_fail++; $display("FAIL rand_sel_ignored: prepare=%b busy=%b credit=%0d want 0000 1 %0d", prepare, busy, credit, m_credit); end
            end
            stop_buy = 1; tick(); stop_buy = 0;
            n_tests++; if (return_cash !== 1'b1 || int'(change_cents) !== m_credit) begin n_fail++; $display("FAIL rand_refund: rc=%b cents=%0d want 1 %0d", return_cash, change_cents, m_credit); end
            tick();
            n_tests++; if (busy !== 1'b0 || credit !== 9'd0) begin n_fail++; $display("FAIL rand_refund_idle: busy=%b credit=%0d want 0 0", busy, credit); end
         end
      end
   endtask

   initial begin
      rst_n = 0; cent20 = 0; cent50 = 0; euro01 = 0; sel = '0;
      stop_buy = 0; prod_ready = 0; cup_out = 0;
      test_reset();
      test_exact_price();
      test_change();
      test_simultaneous();
      test_refund();
      test_timeout();
      test_reject();
      do_reset();
      test_random(40);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
